// File: rtl/mac_sequencer.sv
// ============================================================================
// Module      : mac_sequencer
// Description : Dot-product sequencer. Accepts a vector length, pulls signed
//               16-bit operand pairs over a valid/ready handshake, drives an
//               external fixed-latency sequential multiplier and accumulates
//               the 32-bit products into a 40-bit accumulator. The result is
//               presented on a valid/ready output port.
// Options     : MAC_SAT_EN - when defined, the result presented in DONE is
//               clamped to the signed 32-bit range and out_ovf flags clamping.
//               When undefined, out_data is the raw wrapping accumulator and
//               out_ovf is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_sequencer #(
  parameter int MUL_LATENCY = 34,
  parameter int VEC_LEN_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_start,
  input  logic [VEC_LEN_W-1:0] vec_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [15:0]          in_a,
  input  logic [15:0]          in_b,
  output logic                 mul_start,
  output logic [15:0]          mul_multiplier,
  output logic [15:0]          mul_multiplicand,
  input  logic [31:0]          mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [39:0]          out_data,
  output logic                 out_ovf
);

  // Wait counter only needs to count 0 .. MUL_LATENCY-1.
  localparam int WAIT_CW = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [WAIT_CW-1:0] WAIT_LAST = WAIT_CW'(MUL_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    ACCUM = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t               state;
  state_t               state_nxt;

  logic [VEC_LEN_W-1:0] len_reg;
  logic [VEC_LEN_W-1:0] elem_cnt;
  logic [VEC_LEN_W-1:0] elem_cnt_inc;
  logic [WAIT_CW-1:0]   wait_cnt;
  logic [15:0]          op_a;
  logic [15:0]          op_b;
  logic [39:0]          acc;
  logic [39:0]          product_ext;
  logic                 last_elem;
  logic                 wait_done;

  assign elem_cnt_inc = elem_cnt + 1'b1;
  assign last_elem    = (elem_cnt_inc == len_reg);
  assign wait_done    = (wait_cnt == WAIT_LAST);
  assign product_ext  = {{8{mul_product[31]}}, mul_product};

  // State register; asynchronous reset aborts any command, even mid-multiply.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and the state-decoded control outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (cmd_start) begin
          state_nxt = (vec_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (wait_done) begin
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        state_nxt = last_elem ? DONE : LOAD;
      end
      DONE: begin
        // cmd_start is deliberately not looked at here.
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Command capture, element counting and accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg  <= '0;
      elem_cnt <= '0;
      acc      <= '0;
    end else begin
      if (state == IDLE && cmd_start) begin
        len_reg  <= vec_len;
        elem_cnt <= '0;
        acc      <= '0;
      end else if (state == ACCUM) begin
        elem_cnt <= elem_cnt_inc;
        acc      <= acc + product_ext;
      end
    end
  end

  // Multiplier latency counter: counts the cycles spent in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_done ? '0 : wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Operand registers; only written on the LOAD handshake so they stay
  // frozen while the multiplier works on them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else if (state == LOAD && in_valid) begin
      op_a <= in_a;
      op_b <= in_b;
    end
  end

  assign mul_multiplier   = op_a;
  assign mul_multiplicand = op_b;

`ifdef MAC_SAT_EN
  logic sat_pos;
  logic sat_neg;

  // Above +2^31-1: positive with any of bits 38..31 set.
  // Below -2^31  : negative with any of bits 38..31 clear.
  assign sat_pos = ~acc[39] & (|acc[38:31]);
  assign sat_neg =  acc[39] & ~(&acc[38:31]);

  // Clamp only the presented result; the accumulator itself keeps full range.
  always_comb begin
    out_data = acc;
    out_ovf  = 1'b0;
    if (state == DONE) begin
      if (sat_pos) begin
        out_data = 40'h00_7FFF_FFFF;
        out_ovf  = 1'b1;
      end else if (sat_neg) begin
        out_data = 40'hFF_8000_0000;
        out_ovf  = 1'b1;
      end
    end
  end
`else
  assign out_data = acc;
  assign out_ovf  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_sequencer.sv
// ============================================================================
// Module      : tb_mac_sequencer
// Description : Scoreboard bench for mac_sequencer with a behavioural
//               fixed-latency multiplier model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mac_sequencer;

  localparam int L = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [7:0]  vec_len;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        mul_start;
  logic [15:0] mul_multiplier;
  logic [15:0] mul_multiplicand;
  logic [31:0] mul_product;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_data;
  logic        out_ovf;

  mac_sequencer #(.MUL_LATENCY(L), .VEC_LEN_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_start        (cmd_start),
    .vec_len          (vec_len),
    .busy             (busy),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_a             (in_a),
    .in_b             (in_b),
    .mul_start        (mul_start),
    .mul_multiplier   (mul_multiplier),
    .mul_multiplicand (mul_multiplicand),
    .mul_product      (mul_product),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_ovf          (out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [39:0] data;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   hs_cycle  = 0;
  int   cmd_cycle = 0;
  int   out_cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- multiplier model ----------------
  logic        pending    = 1'b0;
  int          mcnt       = 0;
  logic [31:0] cap_prod   = '0;
  logic [15:0] cap_a      = '0;
  logic [15:0] cap_b      = '0;
  logic        prev_start = 1'b0;
  int          pulses      = 0;
  int          double_puls = 0;
  int          hold_viol   = 0;

  always @(posedge clk) begin
    if (rst) begin
      pending    <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      if (mul_start) begin
        if (prev_start) double_puls++;
        pulses++;
        pending  <= 1'b1;
        mcnt     <= 1;
        cap_a    <= mul_multiplier;
        cap_b    <= mul_multiplicand;
        cap_prod <= $signed(mul_multiplier) * $signed(mul_multiplicand);
      end else if (pending && mcnt < L) begin
        mcnt <= mcnt + 1;
      end
      if (pending && !mul_start && mcnt < L &&
          (mul_multiplier !== cap_a || mul_multiplicand !== cap_b))
        hold_viol++;
      prev_start <= mul_start;
    end
  end

  // Garbage until the latency has elapsed so early sampling is visible.
  assign mul_product = (pending && mcnt >= L) ? cap_prod : 32'hA5A5_5A5A;

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_data", {24'd0, out_data}, {24'd0, e.data});
        check("result_ovf", {63'd0, out_ovf}, {63'd0, e.ovf});
      end
    end
  end

  logic seen_ir = 1'b0;
  always @(negedge clk) if (in_ready) seen_ir <= 1'b1;

  // ---------------- stimulus tasks ----------------
  task automatic start_cmd(input logic [7:0] len);
    @(posedge clk);
    #1;
    cmd_start = 1'b1;
    vec_len   = len;
    cmd_cycle = cycle;
    @(posedge clk);
    #1;
    cmd_start = 1'b0;
  endtask

  task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
    bit got = 1'b0;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got      = 1'b1;
        hs_cycle = cycle;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=no_in_ready required=in_ready");
    end else begin
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit got = 1'b0;
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (out_valid) begin
        got       = 1'b1;
        out_cycle = cycle;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic push_exp(input logic [39:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    exp_q.push_back(e);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0;
    rst       = 1'b1;
    cmd_start = 1'b0;
    vec_len   = '0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd0);
    check("rst_mul_start", {63'd0, mul_start}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  {24'd0, out_data},  64'd0);
    check("rst_out_ovf",   {63'd0, out_ovf},   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single element: 3*4, latency handshake -> out_valid.
    p0 = pulses;
    push_exp(40'd12, 1'b0);
    start_cmd(8'd1);
    check("busy_after_cmd", {63'd0, busy}, 64'd1);
    send_pair(16'd3, 16'd4);
    wait_out();
    check("latency_37", 64'(out_cycle - hs_cycle), 64'd37);
    check("pulses_len1", 64'(pulses - p0), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("busy_clear", {63'd0, busy}, 64'd0);

    // Three mixed-sign pairs: 882 - 108 - 1 = 773.
    p0 = pulses;
    push_exp(40'd773, 1'b0);
    start_cmd(8'd3);
    send_pair(-16'sd42, -16'sd21);
    send_pair(16'sd9, -16'sd12);
    send_pair(-16'sd1, 16'sd1);
    wait_out();
    check("pulses_len3", 64'(pulses - p0), 64'd3);

    // Zero-length command.
    seen_ir = 1'b0;
    push_exp(40'd0, 1'b0);
    start_cmd(8'd0);
    wait_out();
    check("len0_latency", 64'(out_cycle - cmd_cycle), 64'd1);
    check("len0_no_in_ready", {63'd0, seen_ir}, 64'd0);

    // Four maximal products: 4 * 2^30 = 2^32.
`ifdef MAC_SAT_EN
    push_exp(40'd2147483647, 1'b1);
`else
    push_exp(40'd4294967296, 1'b0);
`endif
    start_cmd(8'd4);
    for (int k = 0; k < 4; k++) send_pair(16'h8000, 16'h8000);
    wait_out();

    // Reset in the middle of element 2's multiply.
    start_cmd(8'd3);
    send_pair(16'd1, 16'd1);
    send_pair(16'd2, 16'd2);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_busy",      {63'd0, busy},           64'd0);
    check("mid_rst_out_valid", {63'd0, out_valid},      64'd0);
    check("mid_rst_out_data",  {24'd0, out_data},       64'd0);
    check("mid_rst_mul_a",     {48'd0, mul_multiplier}, 64'd0);
    check("mid_rst_in_ready",  {63'd0, in_ready},       64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_exp(40'd0, 1'b0);
    start_cmd(8'd1);
    send_pair(16'd0, 16'hFFFF);
    wait_out();

    // Back-pressure in DONE with a stray cmd_start: 30 - 56 = -26.
    push_exp(40'hFF_FFFF_FFE6, 1'b0);
    start_cmd(8'd2);
    send_pair(16'd5, 16'd6);
    out_ready = 1'b0;
    send_pair(-16'sd7, 16'sd8);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      cmd_start = (i == 1);
      vec_len   = 8'd1;
      @(negedge clk);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      check("hold_out_data",  {24'd0, out_data},  64'h00FF_FFFF_FFE6);
      check("hold_busy",      {63'd0, busy},      64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ignored_cmd_busy", {63'd0, busy},     64'd0);
      check("ignored_cmd_load", {63'd0, in_ready}, 64'd0);
    end

    check("single_cycle_start", 64'(double_puls), 64'd0);
    check("operand_hold",       64'(hold_viol),   64'd0);
    check("scoreboard_empty",   64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
